// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues host bytes and hands them out one
// at a time, holding each wr_en request until the UART's tx_ready handshake completes.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [7:0]        push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              uart_wr_en,
    output logic [7:0]        uart_data,
    input  logic              uart_tx_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_WAIT
    } state_t;

    localparam logic [ADDR_W:0] L_FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic [7:0]        r_data;
    logic              r_wr_en;
    state_t            r_state;
    state_t            w_next_state;
    logic              w_push_ok;
    logic              w_pop;

    // Full is judged on the registered count, so a push while full is dropped
    // even when a pop frees a slot in the same cycle.
    assign full      = (r_count == L_FULL_COUNT);
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop     = (r_state == S_IDLE) && !empty && uart_tx_ready;

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)          w_next_state = S_OFFER;
            S_OFFER: if (!uart_tx_ready) w_next_state = S_WAIT;
            S_WAIT:  if (uart_tx_ready)  w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wr_en <= (w_next_state == S_OFFER);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_data     <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A dropped push outranks a clear arriving in the same cycle.
            if (push && full) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign count      = r_count;
    assign overflow   = r_overflow;
    assign uart_wr_en = r_wr_en;
    assign uart_data  = r_data;
    assign busy       = (r_state != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a cycle-stepped UART handshake model and a byte
// scoreboard check ordering, flags, counts and reset behaviour.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;
    logic       uart_wr_en;
    logic [7:0] uart_data;
    logic       uart_tx_ready;
    logic       busy;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] sb [$];

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_data     (push_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .uart_wr_en    (uart_wr_en),
        .uart_data     (uart_data),
        .uart_tx_ready (uart_tx_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=simulation still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [7:0] d);
        push      = 1'b1;
        push_data = d;
        tick();
        push      = 1'b0;
    endtask

    // UART model: raise ready, wait for the request, hold it ack_cyc cycles,
    // then report busy for busy_cyc cycles before going idle again.
    task automatic uart_accept(input logic [7:0] exp, input int ack_cyc, input int busy_cyc);
        int waited = 0;
        uart_tx_ready = 1'b1;
        while (!uart_wr_en && waited < 100) begin
            tick();
            waited++;
        end
        chk("wr_en_timeout", uart_wr_en, 1'b1);
        chk("byte", uart_data, exp);
        repeat (ack_cyc) tick();
        chk("held_wr_en", uart_wr_en, 1'b1);
        chk("held_data", uart_data, exp);
        uart_tx_ready = 1'b0;
        tick();
        chk("wr_en_drop", uart_wr_en, 1'b0);
        repeat (busy_cyc) tick();
        uart_tx_ready = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        push          = 1'b0;
        push_data     = 8'h00;
        clr_overflow  = 1'b0;
        uart_tx_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state and single byte latency
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_wr_en", uart_wr_en, 1'b0);
        chk("rst_data", uart_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        do_push(8'hA5);
        chk("t1_count1", count, 1);
        chk("t1_empty0", empty, 1'b0);
        chk("t1_wr_en_early", uart_wr_en, 1'b0);
        tick();
        chk("t1_wr_en", uart_wr_en, 1'b1);
        chk("t1_data", uart_data, 8'hA5);
        chk("t1_count0", count, 0);
        repeat (10) tick();
        chk("t1_held", uart_wr_en, 1'b1);
        uart_tx_ready = 1'b0;
        tick();
        chk("t1_wr_en_fall", uart_wr_en, 1'b0);
        chk("t1_busy_wait", busy, 1'b1);
        uart_tx_ready = 1'b1;
        tick();
        chk("t1_busy_idle", busy, 1'b0);

        // 2: fill to full, overflow and clear
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) do_push(8'(i));
        chk("t2_full", full, 1'b1);
        chk("t2_count16", count, 16);
        chk("t2_no_ovf", overflow, 1'b0);
        do_push(8'hFF);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_count_stay", count, 16);
        clr_overflow = 1'b1;
        tick();
        chk("t2_clr", overflow, 1'b0);
        push      = 1'b1;
        push_data = 8'hEE;
        tick();
        push         = 1'b0;
        chk("t2_drop_wins", overflow, 1'b1);
        tick();
        clr_overflow = 1'b0;
        chk("t2_clr2", overflow, 1'b0);

        // 3: drain in order through the UART model
        for (int i = 0; i < 16; i++) uart_accept(8'(i), 5, 40);
        tick();
        chk("t3_empty", empty, 1'b1);
        chk("t3_busy", busy, 1'b0);

        // 4: simultaneous push+pop at count 15 and at count 16
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 15; i++) do_push(8'h40 + 8'(i));
        chk("t4_count15", count, 15);
        uart_tx_ready = 1'b1;
        do_push(8'h4F);
        chk("t4_pp15_count", count, 15);
        chk("t4_pp15_wr_en", uart_wr_en, 1'b1);
        chk("t4_pp15_data", uart_data, 8'h40);
        uart_tx_ready = 1'b0;
        tick();
        do_push(8'h50);
        chk("t4_count16", count, 16);
        uart_tx_ready = 1'b1;
        tick();
        do_push(8'h51);
        chk("t4_pp16_count", count, 15);
        chk("t4_pp16_ovf", overflow, 1'b1);
        chk("t4_pp16_data", uart_data, 8'h41);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        for (int i = 'h41; i <= 'h50; i++) uart_accept(8'(i), 1, 2);
        tick();
        chk("t4_empty", empty, 1'b0 == 1'b1 ? 1'b0 : 1'b1);

        // 5: wrap-around with random bursts against a scoreboard
        begin
            int pushed = 0;
            while (pushed < 53 || sb.size() > 0) begin
                uart_tx_ready = 1'b0;
                if (pushed < 53) begin
                    int n = $urandom_range(1, 8);
                    if (n > 16 - sb.size()) n = 16 - sb.size();
                    if (n > 53 - pushed) n = 53 - pushed;
                    for (int k = 0; k < n; k++) begin
                        logic [7:0] b = 8'($urandom);
                        sb.push_back(b);
                        do_push(b);
                        pushed++;
                    end
                    chk("t5_count", count, sb.size());
                end
                if (sb.size() > 0) begin
                    int m = (pushed < 53) ? $urandom_range(1, sb.size()) : sb.size();
                    for (int k = 0; k < m; k++) uart_accept(sb.pop_front(), 1, 2);
                end
            end
            tick();
            chk("t5_empty", empty, 1'b1);
            chk("t5_no_ovf", overflow, 1'b0);
        end

        // 6: reset while a request is being offered
        uart_tx_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) do_push(8'h70 + 8'(i));
        uart_tx_ready = 1'b1;
        tick();
        chk("t6_offer", uart_wr_en, 1'b1);
        chk("t6_count4", count, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_wr_en", uart_wr_en, 1'b0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_count", count, 0);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_busy", busy, 1'b0);
        do_push(8'h3C);
        uart_accept(8'h3C, 2, 3);
        tick();
        chk("t6_end_empty", empty, 1'b1);
        chk("t6_end_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
